seq_arith_unit: RTL and testbench
=================================

Name: seq_arith_unit

Overview:
Parametrised, multi-cycle successor to the Y → shifter → ALU → comparator → Z datapath slice.
- Captures two operands and an opcode on a start handshake.
- Shifts the Y operand iteratively, one bit per cycle, by any amount up to WIDTH-1.
- Executes one ALU op, latches the result into Z with four condition codes, and pulses done.
- Sits between the CPU bus and the control sequencer, which now issues a single start instead of a hand-sequenced Y_in/Z_in control pattern.

Parameters:
- WIDTH, 16, datapath width in bits; power of two, ≥ 8.
- SHAMT_W, $clog2(WIDTH), width of the shift-amount field.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only when busy=0.
- a_data  in  WIDTH  ALU operand A (bus side); captured at start.
- y_data  in  WIDTH  operand loaded into Y; captured at start.
- alu_op  in  3  operation code; captured at start.
- shift_mode  in  2  00 none, 01 LSL, 10 LSR, 11 ASR; captured at start.
- shift_amount  in  SHAMT_W  bit count; captured at start.
- z_oe  in  1  drive Z onto bus_out.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse when Z and flags update.
- z_value  out  WIDTH  Z register, always visible.
- bus_out  out  WIDTH  z_oe ? Z : 0 (combinational).
- cc_z, cc_n, cc_c, cc_v  out  1 each  condition codes, registered.

Behaviour:
- Reset values: state IDLE; Y, A, Z, counter, flags all 0; busy=0; done=0; bus_out follows z_oe with Z=0. Reset mid-operation aborts immediately; the in-flight result is discarded.
- States: IDLE, SHIFT, EXEC, DONE.
- IDLE: when start=1, capture all inputs at edge T.
  - If shift_mode=00 or shift_amount=0: go to EXEC.
  - Otherwise: go to SHIFT with counter = shift_amount.
- SHIFT: each edge shifts Y by one bit and decrements the counter.
  - LSL and LSR fill with 0; ASR replicates the MSB.
  - When the counter is 1 at the edge, go to EXEC.
- EXEC: R = f(A, Y). At the edge, Z ← R, flags update, go to DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE.
- Latency: Z, flags and done update at edge T+n+1, where n is the effective shift count (0 if mode=00). done falls at T+n+2, and busy falls at the same edge.
- start while busy=1 (including DONE) is ignored, with no queuing. start held high in IDLE after DONE begins a new operation.
- alu_op encoding:
  - 000 PASS_A
  - 001 ADD (A+Y)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT_Y
  - 110 SUB (A−Y, computed as A+~Y+1)
  - 111 PASS_Y
- Flags:
  - cc_z = (R==0).
  - cc_n = R[WIDTH-1].
  - ADD/SUB: cc_c = carry-out of the WIDTH-bit adder, so C=1 means "no borrow" for SUB. cc_v = signed overflow.
  - All other ops: cc_c = cc_v = 0.
- Arithmetic is modulo 2^WIDTH. Z and flags hold their values between operations and change only at EXEC.
- Input changes after edge T have no effect on the running operation.

Decomposition:
- Package arith_pkg:
  - ALU op localparams (OP_PASS_A … OP_PASS_Y).
  - Shift-mode localparams (SH_NONE, SH_LSL, SH_LSR, SH_ASR).
  - FSM state encoding (S_IDLE, S_SHIFT, S_EXEC, S_DONE).
- Sub-module: one combinational alu_core (WIDTH-parametrised; inputs a, y, op; outputs r, c, v). The top module holds the FSM, the Y shift register, the counter, the Z register and the flag registers.

Test Plan:
1. Reset asserted asynchronously mid-cycle → busy=0, done=0, z_value=0, all flags 0 immediately; with z_oe=1, bus_out=0.
2. a=ABAA, y=ABAA, ASR, amount 3, SUB, start at T → Y=F575 after T+3; Z=B635, N=1, Z=0, C=0, V=0, done high at T+4 only; z_oe=1 gives bus_out=B635.
3. a=7FFF, y=0001, mode 01, amount 0, ADD → no SHIFT state; Z=8000, N=1, V=1, C=0, done at T+1.
4. a=1234, y=1234, mode 00, amount 5, SUB → amount ignored (n=0); Z=0000, cc_z=1, C=1, V=0, done at T+1.
5. y=0003, LSL, amount 15, PASS_Y; extra start pulses at T+2 and T+16 → Z=8000, done at T+16 only, one operation executed; then LSR 15 on y=8000 gives 0001, and ASR 15 on y=8000 gives FFFF.
6. Reset pulse at T+2 during a 10-bit shift → IDLE, Z=0, no done; the next start with a=0005, y=0003, ADD gives Z=0008 at T'+1.

Source files
------------

// File: rtl/seq_arith_unit_pkg.sv
// Shared encodings for the sequential arithmetic unit: ALU opcodes, shift modes
// and FSM states.
package arith_pkg;

    localparam logic [2:0] OP_PASS_A = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b001;
    localparam logic [2:0] OP_AND    = 3'b010;
    localparam logic [2:0] OP_OR     = 3'b011;
    localparam logic [2:0] OP_XOR    = 3'b100;
    localparam logic [2:0] OP_NOT_Y  = 3'b101;
    localparam logic [2:0] OP_SUB    = 3'b110;
    localparam logic [2:0] OP_PASS_Y = 3'b111;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_EXEC  = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

endpackage

// File: rtl/seq_arith_unit_alu_core.sv
// Combinational ALU: one shared adder serves ADD and SUB (A + ~Y + 1).
module alu_core
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] r,
    output logic             c,
    output logic             v
);

    logic             sub;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;

    always_comb begin
        sub = (op == OP_SUB);
        b   = sub ? ~y : y;
        sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, sub};
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_PASS_A: r = a;
            OP_ADD, OP_SUB: begin
                r = sum[WIDTH-1:0];
                c = sum[WIDTH];
                // Overflow: both adder inputs share a sign the result lacks.
                v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:    r = a & y;
            OP_OR:     r = a | y;
            OP_XOR:    r = a ^ y;
            OP_NOT_Y:  r = ~y;
            OP_PASS_Y: r = y;
            default:   r = '0;
        endcase
    end

endmodule

// File: rtl/seq_arith_unit.sv
// Multi-cycle Y -> shifter -> ALU -> Z slice. Handshake: start is accepted only
// while busy=0; done pulses for one cycle when Z and the flags have updated.
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_data,
    input  logic [WIDTH-1:0]   y_data,
    input  logic [2:0]         alu_op,
    input  logic [1:0]         shift_mode,
    input  logic [SHAMT_W-1:0] shift_amount,
    input  logic               z_oe,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   z_value,
    output logic [WIDTH-1:0]   bus_out,
    output logic               cc_z,
    output logic               cc_n,
    output logic               cc_c,
    output logic               cc_v
);

    logic [1:0]         state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   y_q;
    logic [2:0]         op_q;
    logic [1:0]         mode_q;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   y_next;
    logic [WIDTH-1:0]   r;
    logic               c;
    logic               v;

    always_comb begin
        y_next = y_q;
        case (mode_q)
            SH_LSL:  y_next = {y_q[WIDTH-2:0], 1'b0};
            SH_LSR:  y_next = {1'b0, y_q[WIDTH-1:1]};
            SH_ASR:  y_next = {y_q[WIDTH-1], y_q[WIDTH-1:1]};
            default: y_next = y_q;
        endcase
    end

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .a  (a_q),
        .y  (y_q),
        .op (op_q),
        .r  (r),
        .c  (c),
        .v  (v)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            a_q     <= '0;
            y_q     <= '0;
            op_q    <= '0;
            mode_q  <= '0;
            cnt     <= '0;
            z_value <= '0;
            cc_z    <= 1'b0;
            cc_n    <= 1'b0;
            cc_c    <= 1'b0;
            cc_v    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q    <= a_data;
                        y_q    <= y_data;
                        op_q   <= alu_op;
                        mode_q <= shift_mode;
                        if (shift_mode == SH_NONE || shift_amount == '0) begin
                            state <= S_EXEC;
                        end else begin
                            cnt   <= shift_amount;
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    y_q <= y_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == 1) state <= S_EXEC;
                end
                S_EXEC: begin
                    z_value <= r;
                    cc_z    <= (r == '0);
                    cc_n    <= r[WIDTH-1];
                    cc_c    <= c;
                    cc_v    <= v;
                    state   <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign bus_out = z_oe ? z_value : '0;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit: hand-computed results, flags and latencies.
module tb_seq_arith_unit;
    import arith_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a_data = '0;
    logic [15:0] y_data = '0;
    logic [2:0]  alu_op = '0;
    logic [1:0]  shift_mode = '0;
    logic [3:0]  shift_amount = '0;
    logic        z_oe = 1'b0;
    logic        busy, done, cc_z, cc_n, cc_c, cc_v;
    logic [15:0] z_value, bus_out;

    int n_checks = 0;
    int n_pass = 0;

    seq_arith_unit #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .a_data(a_data), .y_data(y_data),
        .alu_op(alu_op), .shift_mode(shift_mode), .shift_amount(shift_amount),
        .z_oe(z_oe), .busy(busy), .done(done), .z_value(z_value), .bus_out(bus_out),
        .cc_z(cc_z), .cc_n(cc_n), .cc_c(cc_c), .cc_v(cc_v)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    // Start one op, scramble inputs after capture, then check latency, Z and flags.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] y,
                          input logic [2:0] op, input logic [1:0] mode, input logic [3:0] amt,
                          input int lat, input logic [15:0] ez, input logic [3:0] ef);
        int k;
        @(negedge clk);
        a_data = a; y_data = y; alu_op = op; shift_mode = mode; shift_amount = amt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a_data = 16'($urandom); y_data = 16'($urandom);
        alu_op = 3'($urandom); shift_mode = 2'($urandom); shift_amount = 4'($urandom);
        check({tag, "_busy"}, busy, 1);
        k = 0;
        while (!done && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_lat"}, k, lat);
        check({tag, "_z"}, z_value, ez);
        check({tag, "_flags"}, {cc_z, cc_n, cc_c, cc_v}, ef);
        @(posedge clk); #1;
        check({tag, "_done_fall"}, {done, busy}, 2'b00);
    endtask

    initial begin
        int done_cnt;
        int done_cyc;

        #12;
        check("rst_init", {busy, done, z_value, cc_z, cc_n, cc_c, cc_v}, 0);
        @(negedge clk); reset = 1'b0;

        // ABAA >>> 3 = F575; ABAA - F575 = B635 with borrow
        z_oe = 1'b1;
        run_op("sub_asr", 16'hABAA, 16'hABAA, OP_SUB, SH_ASR, 4'd3, 4, 16'hB635, 4'b0100);
        check("bus_oe1", bus_out, 16'hB635);
        z_oe = 1'b0; #1;
        check("bus_oe0", bus_out, 16'h0000);

        run_op("add_ovf", 16'h7FFF, 16'h0001, OP_ADD, SH_LSL, 4'd0, 1, 16'h8000, 4'b0101);
        run_op("sub_eq", 16'h1234, 16'h1234, OP_SUB, SH_NONE, 4'd5, 1, 16'h0000, 4'b1010);
        run_op("and", 16'hF0F0, 16'h0FF0, OP_AND, SH_NONE, 4'd0, 1, 16'h00F0, 4'b0000);
        run_op("or", 16'hF000, 16'h000F, OP_OR, SH_NONE, 4'd0, 1, 16'hF00F, 4'b0100);
        run_op("xor", 16'hAAAA, 16'hAAAA, OP_XOR, SH_NONE, 4'd0, 1, 16'h0000, 4'b1000);
        run_op("not_y", 16'h1234, 16'h0000, OP_NOT_Y, SH_NONE, 4'd0, 1, 16'hFFFF, 4'b0100);
        run_op("pass_a", 16'h0000, 16'h5555, OP_PASS_A, SH_NONE, 4'd0, 1, 16'h0000, 4'b1000);
        run_op("sub_borrow", 16'h0000, 16'h0001, OP_SUB, SH_NONE, 4'd0, 1, 16'hFFFF, 4'b0100);
        run_op("sub_ovf", 16'h8000, 16'h0001, OP_SUB, SH_NONE, 4'd0, 1, 16'h7FFF, 4'b0011);
        run_op("add_wrap", 16'hFFFF, 16'h0001, OP_ADD, SH_NONE, 4'd0, 1, 16'h0000, 4'b1010);
        run_op("lsr4", 16'h0000, 16'hF000, OP_PASS_Y, SH_LSR, 4'd4, 5, 16'h0F00, 4'b0000);

        // LSL 15 with start pulses at T+2 and T+16 that must be ignored
        @(negedge clk);
        a_data = 16'h0000; y_data = 16'h0003; alu_op = OP_PASS_Y;
        shift_mode = SH_LSL; shift_amount = 4'd15; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cnt = 0; done_cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            start = (k == 2 || k == 16);
            a_data = 16'hFFFF; alu_op = OP_PASS_A; shift_mode = SH_NONE;
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                done_cyc = k;
            end
        end
        start = 1'b0;
        check("lsl15_done_cnt", done_cnt, 1);
        check("lsl15_done_cyc", done_cyc, 16);
        check("lsl15_z", z_value, 16'h8000);
        check("lsl15_idle", busy, 0);

        run_op("lsr15", 16'h0000, 16'h8000, OP_PASS_Y, SH_LSR, 4'd15, 16, 16'h0001, 4'b0000);
        run_op("asr15", 16'h0000, 16'h8000, OP_PASS_Y, SH_ASR, 4'd15, 16, 16'hFFFF, 4'b0100);

        // Asynchronous reset between edges clears everything without a clock edge
        z_oe = 1'b1;
        @(negedge clk); #2;
        reset = 1'b1; #1;
        check("rst_async", {busy, done, z_value, cc_z, cc_n, cc_c, cc_v}, 0);
        check("rst_bus", bus_out, 16'h0000);
        @(negedge clk); reset = 1'b0;

        // Abort a 10-bit shift with a reset pulse around T+2
        @(negedge clk);
        a_data = 16'h1111; y_data = 16'h0001; alu_op = OP_ADD;
        shift_mode = SH_LSL; shift_amount = 4'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); reset = 1'b1; #1;
        check("abort_busy", busy, 0);
        @(negedge clk); reset = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_z", z_value, 16'h0000);
        run_op("post_abort", 16'h0005, 16'h0003, OP_ADD, SH_NONE, 4'd0, 1, 16'h0008, 4'b0000);
        check("post_abort_bus", bus_out, 16'h0008);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
